// File: rtl/team_proj_pkg.sv
// Shared definitions for the team project register slice: register offsets,
// the bus handshake state type, the prescaler width default and a byte-lane
// merge helper used by the register write path.
package team_proj_pkg;

    localparam int PRESC_W_DFLT = 14;

    localparam logic [31:0] EN_OFF    = 32'h0000_0000;
    localparam logic [31:0] PRESC_OFF = 32'h0000_0004;
    localparam logic [31:0] IM_OFF    = 32'h0000_FF00;
    localparam logic [31:0] MIS_OFF   = 32'h0000_FF04;
    localparam logic [31:0] RIS_OFF   = 32'h0000_FF08;
    localparam logic [31:0] IC_OFF    = 32'h0000_FF0C;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_ACK  = 1'b1
    } wb_state_t;

    // Replace each byte of old_v whose select bit is set with the same byte of new_v.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/team_proj_irq_ctrl.sv
// Interrupt bookkeeping: sticky raw status (RIS), mask (IM), masked status (MIS), irq line.
// Latency: RIS/IM update on the clock after the event or write; irq follows one clock later.
// Backpressure: none; event pulses are always captured, set wins over a same-cycle clear.
// Ports: clk_i/rst_i (sync, active-high), evt_i event pulses, im_we_i/im_wdat_i mask write,
//        ic_we_i/ic_wdat_i write-1-to-clear, im_o/ris_o/mis_o status, irq_o registered OR of MIS.
module team_proj_irq_ctrl #(
    parameter int NUM_IRQ = 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] evt_i,
    input  logic               im_we_i,
    input  logic [NUM_IRQ-1:0] im_wdat_i,
    input  logic               ic_we_i,
    input  logic [NUM_IRQ-1:0] ic_wdat_i,
    output logic [NUM_IRQ-1:0] im_o,
    output logic [NUM_IRQ-1:0] ris_o,
    output logic [NUM_IRQ-1:0] mis_o,
    output logic               irq_o
);

    logic [NUM_IRQ-1:0] im_q, im_d;
    logic [NUM_IRQ-1:0] ris_q, ris_d;
    logic               irq_q, irq_d;
    logic [NUM_IRQ-1:0] clr;

    always_comb begin
        clr   = ic_we_i ? ic_wdat_i : '0;
        im_d  = im_we_i ? im_wdat_i : im_q;
        // Clear first, then OR in new events so a coincident event is never lost.
        ris_d = (ris_q & ~clr) | evt_i;
        irq_d = |(ris_q & im_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            im_q  <= '0;
            ris_q <= '0;
            irq_q <= 1'b0;
        end else begin
            im_q  <= im_d;
            ris_q <= ris_d;
            irq_q <= irq_d;
        end
    end

    assign im_o  = im_q;
    assign ris_o = ris_q;
    assign mis_o = ris_q & im_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/team_proj_wb_regs.sv
// Wishbone classic slave register block feeding the project core (enable, prescaler, interrupts).
// Latency: write commits and read data is captured on the request cycle; ack the cycle after.
// Backpressure: none; every request is acked once, with an idle cycle between acks.
// Ports: wb_clk_i/wb_rst_i (sync, active-high), wbs_* Wishbone slave, evt_i core events,
//        en_o core enable, prescaler_o core prescaler, irq interrupt line.
module team_proj_wb_regs
    import team_proj_pkg::*;
#(
    parameter int ADR_W     = 16,
    parameter int PRESC_W   = PRESC_W_DFLT,
    parameter int PRESC_RST = 1,
    parameter int NUM_IRQ   = 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,
    input  logic [NUM_IRQ-1:0] evt_i,
    output logic               en_o,
    output logic [PRESC_W-1:0] prescaler_o,
    output logic               irq
);

    localparam logic [31:0] ADR_MASK = 32'((64'd1 << ADR_W) - 64'd1);

    wb_state_t          state_q, state_d;
    logic               en_q, en_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [31:0]        rdat_q, rdat_d;

    logic               req, wr, rd;
    logic [31:0]        adr_off;
    logic [31:0]        presc_merged;
    logic               im_we, ic_we;
    logic [NUM_IRQ-1:0] im, ris, mis;
    logic               unused_merge;

    assign adr_off = wbs_adr_i & ADR_MASK;
    assign req     = (state_q == WB_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign wr      = req && wbs_we_i;
    assign rd      = req && !wbs_we_i;

    assign presc_merged = lane_merge(32'(presc_q), wbs_dat_i, wbs_sel_i);
    assign unused_merge = ^presc_merged;

    // Handshake: one ack cycle per request, always followed by IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (wbs_cyc_i && wbs_stb_i) state_d = WB_ACK;
            WB_ACK:  state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    always_comb begin
        en_d    = en_q;
        presc_d = presc_q;
        if (wr && (adr_off == EN_OFF) && wbs_sel_i[0]) en_d = wbs_dat_i[0];
        if (wr && (adr_off == PRESC_OFF))              presc_d = presc_merged[PRESC_W-1:0];
    end

    // Read data is captured with the request and cleared on every other cycle.
    always_comb begin
        rdat_d = '0;
        if (rd) begin
            case (adr_off)
                EN_OFF:    rdat_d = {31'd0, en_q};
                PRESC_OFF: rdat_d = 32'(presc_q);
                IM_OFF:    rdat_d = 32'(im);
                MIS_OFF:   rdat_d = 32'(mis);
                RIS_OFF:   rdat_d = 32'(ris);
                default:   rdat_d = '0;
            endcase
        end
    end

    assign im_we = wr && (adr_off == IM_OFF) && wbs_sel_i[0];
    assign ic_we = wr && (adr_off == IC_OFF) && wbs_sel_i[0];

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= WB_IDLE;
            en_q    <= 1'b0;
            presc_q <= PRESC_W'(PRESC_RST);
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            presc_q <= presc_d;
            rdat_q  <= rdat_d;
        end
    end

    team_proj_irq_ctrl #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_ctrl (
        .clk_i     (wb_clk_i),
        .rst_i     (wb_rst_i),
        .evt_i     (evt_i),
        .im_we_i   (im_we),
        .im_wdat_i (wbs_dat_i[NUM_IRQ-1:0]),
        .ic_we_i   (ic_we),
        .ic_wdat_i (wbs_dat_i[NUM_IRQ-1:0]),
        .im_o      (im),
        .ris_o     (ris),
        .mis_o     (mis),
        .irq_o     (irq)
    );

    // A master that drops cyc before sampling ack has abandoned the cycle, so ack is masked.
    assign wbs_ack_o   = (state_q == WB_ACK) && wbs_cyc_i;
    assign wbs_dat_o   = wbs_ack_o ? rdat_q : 32'd0;
    assign en_o        = en_q;
    assign prescaler_o = presc_q;

endmodule
